// File: rtl/hs_io_fx2_emu.sv
// ============================================================================
// Module   : hs_io_fx2_emu
// Brief    : FX2 Slave FIFO emulator (EP2 host->FPGA, EP6 FPGA->host) with
//            host-side word FIFO ports. Optional flag stall: HS_IO_EMU_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_io_fx2_emu #(
    parameter int EP2_DEPTH_LOG  = 10,
    parameter int EP6_DEPTH_LOG  = 10,
    parameter int PKT_WORDS      = 256,
    parameter int EP6_PROG_LEVEL = 768
) (
    input  logic        IFCLK,
    input  logic        RESET_N,
    input  logic [1:0]  FIFOADR,
    input  logic        SLOE,
    input  logic        SLRD,
    input  logic        SLWR,
    input  logic        PKTEND,
    input  logic [15:0] FIFO_DATA_IN,
    output logic [15:0] FIFO_DATA_OUT,
    output logic        FIFO_DATA_OE,
    output logic        FLAGA,
    output logic        FLAGB,
    output logic        FLAGC,
    input  logic [15:0] host_din,
    input  logic        host_wr_en,
    input  logic        host_commit,
    output logic        host_full,
    output logic [15:0] host_dout,
    input  logic        host_rd_en,
    output logic        host_empty,
    output logic [15:0] host_pkt_cnt,
    output logic [3:0]  err
);

    localparam int c_ep2_words = 1 << EP2_DEPTH_LOG;
    localparam int c_ep6_words = 1 << EP6_DEPTH_LOG;
    localparam logic [EP2_DEPTH_LOG:0] c_ep2_full = {1'b1, {EP2_DEPTH_LOG{1'b0}}};
    localparam logic [EP6_DEPTH_LOG:0] c_ep6_full = {1'b1, {EP6_DEPTH_LOG{1'b0}}};
    localparam logic [EP6_DEPTH_LOG:0] c_ep6_pkt  = (EP6_DEPTH_LOG+1)'(PKT_WORDS);
    localparam logic [EP6_DEPTH_LOG:0] c_ep6_prog = (EP6_DEPTH_LOG+1)'(EP6_PROG_LEVEL);

    logic [15:0] r_ep2_mem [c_ep2_words];
    logic [15:0] r_ep6_mem [c_ep6_words];

    logic [EP2_DEPTH_LOG:0] r_ep2_wr, r_ep2_cm, r_ep2_rd;
    logic [EP6_DEPTH_LOG:0] r_ep6_wr, r_ep6_cm, r_ep6_rd;
    logic [15:0]            r_pkt_cnt;
    logic [3:0]             r_err;
    logic                   r_flagb, r_flagc;

    logic [EP2_DEPTH_LOG:0] w_ep2_fill, w_ep2_cmtd, w_ep2_wr_nx, w_ep2_cm_nx, w_ep2_rd_nx, w_ep2_cmtd_nx;
    logic [EP6_DEPTH_LOG:0] w_ep6_fill, w_ep6_cmtd, w_ep6_wr_nx, w_ep6_cm_nx, w_ep6_rd_nx, w_ep6_fill_nx;
    logic [EP6_DEPTH_LOG:0] w_ep6_pend_nx;
    logic w_addr_ep2, w_addr_ep6, w_addr_bad, w_both;
    logic w_rd_req, w_wr_req, w_pkt_req;
    logic w_ep2_load, w_ep2_pop, w_ep6_push, w_ep6_pop, w_ep6_commit;
    logic w_err_und, w_err_ovr, w_err_addr, w_err_conf;
    logic w_flagb_nx, w_flagc_nx;

    assign w_addr_ep2 = (FIFOADR == 2'b00);
    assign w_addr_ep6 = (FIFOADR == 2'b10);
    assign w_addr_bad = FIFOADR[0];
    assign w_both     = !SLRD && !SLWR;

    assign w_rd_req  = !SLRD && w_addr_ep2 && !w_both;
    assign w_wr_req  = !SLWR && w_addr_ep6 && !w_both;
    assign w_pkt_req = !PKTEND && w_addr_ep6;

    assign w_ep2_fill = r_ep2_wr - r_ep2_rd;
    assign w_ep2_cmtd = r_ep2_cm - r_ep2_rd;
    assign w_ep6_fill = r_ep6_wr - r_ep6_rd;
    assign w_ep6_cmtd = r_ep6_cm - r_ep6_rd;

    assign host_full  = (w_ep2_fill == c_ep2_full);
    assign host_empty = (w_ep6_cmtd == '0);

    assign w_ep2_load = host_wr_en && !host_full;
    assign w_ep2_pop  = w_rd_req && (w_ep2_cmtd != '0);
    assign w_ep6_push = w_wr_req && (w_ep6_fill != c_ep6_full);
    assign w_ep6_pop  = host_rd_en && !host_empty;

    // OE implies FIFOADR==00, so a contending SLWR is never an EP6 write anyway.
    assign w_err_und  = w_rd_req && (w_ep2_cmtd == '0);
    assign w_err_ovr  = w_wr_req && (w_ep6_fill == c_ep6_full);
    assign w_err_addr = w_addr_bad && (!SLRD || !SLWR || !PKTEND);
    assign w_err_conf = w_both || (!SLWR && FIFO_DATA_OE);

    assign w_ep2_wr_nx   = r_ep2_wr + {{EP2_DEPTH_LOG{1'b0}}, w_ep2_load};
    assign w_ep2_rd_nx   = r_ep2_rd + {{EP2_DEPTH_LOG{1'b0}}, w_ep2_pop};
    assign w_ep2_cm_nx   = host_commit ? w_ep2_wr_nx : r_ep2_cm;
    assign w_ep2_cmtd_nx = w_ep2_cm_nx - w_ep2_rd_nx;

    // Commit decisions see the word written this cycle, for PKTEND and auto-commit alike.
    assign w_ep6_wr_nx   = r_ep6_wr + {{EP6_DEPTH_LOG{1'b0}}, w_ep6_push};
    assign w_ep6_rd_nx   = r_ep6_rd + {{EP6_DEPTH_LOG{1'b0}}, w_ep6_pop};
    assign w_ep6_pend_nx = w_ep6_wr_nx - r_ep6_cm;
    assign w_ep6_commit  = w_pkt_req || (w_ep6_pend_nx == c_ep6_pkt);
    assign w_ep6_cm_nx   = w_ep6_commit ? w_ep6_wr_nx : r_ep6_cm;
    assign w_ep6_fill_nx = w_ep6_wr_nx - w_ep6_rd_nx;

`ifdef HS_IO_EMU_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
`endif

    always_comb begin
        w_flagb_nx = 1'b1;
        w_flagc_nx = 1'b0;
        case (FIFOADR)
            2'b00: begin
                w_flagb_nx = 1'b1;
                w_flagc_nx = (w_ep2_cmtd_nx != '0);
            end
            2'b10: begin
                w_flagb_nx = (w_ep6_fill_nx != c_ep6_full);
                w_flagc_nx = (w_ep6_fill_nx != '0);
            end
            default: begin
                w_flagb_nx = 1'b0;
                w_flagc_nx = 1'b0;
            end
        endcase
`ifdef HS_IO_EMU_STALL_EN
        if (r_lfsr[2:0] == 3'b000) begin
            w_flagb_nx = 1'b0;
            w_flagc_nx = 1'b0;
        end
`endif
    end

    always_ff @(posedge IFCLK) begin
        if (w_ep2_load) r_ep2_mem[r_ep2_wr[EP2_DEPTH_LOG-1:0]] <= host_din;
        if (w_ep6_push) r_ep6_mem[r_ep6_wr[EP6_DEPTH_LOG-1:0]] <= FIFO_DATA_IN;
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ep2_wr  <= '0;
            r_ep2_cm  <= '0;
            r_ep2_rd  <= '0;
            r_ep6_wr  <= '0;
            r_ep6_cm  <= '0;
            r_ep6_rd  <= '0;
            r_pkt_cnt <= '0;
            r_err     <= '0;
            r_flagb   <= 1'b1;
            r_flagc   <= 1'b0;
        end else begin
            r_ep2_wr  <= w_ep2_wr_nx;
            r_ep2_cm  <= w_ep2_cm_nx;
            r_ep2_rd  <= w_ep2_rd_nx;
            r_ep6_wr  <= w_ep6_wr_nx;
            r_ep6_cm  <= w_ep6_cm_nx;
            r_ep6_rd  <= w_ep6_rd_nx;
            r_pkt_cnt <= r_pkt_cnt + {15'd0, w_ep6_commit};
            r_err     <= r_err | {w_err_conf, w_err_addr, w_err_ovr, w_err_und};
            r_flagb   <= w_flagb_nx;
            r_flagc   <= w_flagc_nx;
        end
    end

    // Data outputs read as zero when nothing is committed so reset leaves them clean.
    assign FIFO_DATA_OUT = (w_ep2_cmtd != '0) ? r_ep2_mem[r_ep2_rd[EP2_DEPTH_LOG-1:0]] : 16'h0000;
    assign host_dout     = host_empty ? 16'h0000 : r_ep6_mem[r_ep6_rd[EP6_DEPTH_LOG-1:0]];
    assign FIFO_DATA_OE  = RESET_N && !SLOE && w_addr_ep2;
    assign FLAGA         = !(w_ep6_fill >= c_ep6_prog);
    assign FLAGB         = r_flagb;
    assign FLAGC         = r_flagc;
    assign host_pkt_cnt  = r_pkt_cnt;
    assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hs_io_fx2_emu.sv
// ============================================================================
// Module   : tb_hs_io_fx2_emu
// Brief    : Self-checking bench for hs_io_fx2_emu using per-endpoint scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_io_fx2_emu;

    logic        IFCLK = 1'b0;
    logic        RESET_N;
    logic [1:0]  FIFOADR;
    logic        SLOE, SLRD, SLWR, PKTEND;
    logic [15:0] FIFO_DATA_IN;
    logic [15:0] FIFO_DATA_OUT;
    logic        FIFO_DATA_OE, FLAGA, FLAGB, FLAGC;
    logic [15:0] host_din;
    logic        host_wr_en, host_commit, host_full;
    logic [15:0] host_dout;
    logic        host_rd_en, host_empty;
    logic [15:0] host_pkt_cnt;
    logic [3:0]  err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_pkt  = 0;
    logic [15:0] ep2_q[$];
    logic [15:0] ep6_q[$];

    always #5 IFCLK = ~IFCLK;

    hs_io_fx2_emu dut (
        .IFCLK        (IFCLK),
        .RESET_N      (RESET_N),
        .FIFOADR      (FIFOADR),
        .SLOE         (SLOE),
        .SLRD         (SLRD),
        .SLWR         (SLWR),
        .PKTEND       (PKTEND),
        .FIFO_DATA_IN (FIFO_DATA_IN),
        .FIFO_DATA_OUT(FIFO_DATA_OUT),
        .FIFO_DATA_OE (FIFO_DATA_OE),
        .FLAGA        (FLAGA),
        .FLAGB        (FLAGB),
        .FLAGC        (FLAGC),
        .host_din     (host_din),
        .host_wr_en   (host_wr_en),
        .host_commit  (host_commit),
        .host_full    (host_full),
        .host_dout    (host_dout),
        .host_rd_en   (host_rd_en),
        .host_empty   (host_empty),
        .host_pkt_cnt (host_pkt_cnt),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge IFCLK);
        #1;
    endtask

    task automatic sb_ep2(input string tag);
        if (ep2_q.size() == 0) chk({tag, "_sbq"}, ep2_q.size(), 1);
        else                   chk(tag, FIFO_DATA_OUT, ep2_q.pop_front());
    endtask

    task automatic sb_ep6(input string tag);
        if (ep6_q.size() == 0) chk({tag, "_sbq"}, ep6_q.size(), 1);
        else                   chk(tag, host_dout, ep6_q.pop_front());
    endtask

    task automatic fpga_write(input logic [15:0] d, input bit expect_store);
        FIFOADR = 2'b10; SLWR = 1'b0; FIFO_DATA_IN = d;
        if (expect_store) ep6_q.push_back(d);
        tick();
        SLWR = 1'b1;
    endtask

    task automatic host_drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sb_ep6(tag);
            host_rd_en = 1'b1;
            tick();
            host_rd_en = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flaga"}, FLAGA, 1);
        chk({tag, "_flagb"}, FLAGB, 1);
        chk({tag, "_flagc"}, FLAGC, 0);
        chk({tag, "_oe"}, FIFO_DATA_OE, 0);
        chk({tag, "_dout"}, FIFO_DATA_OUT, 0);
        chk({tag, "_hempty"}, host_empty, 1);
        chk({tag, "_hfull"}, host_full, 0);
        chk({tag, "_pkt"}, host_pkt_cnt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        RESET_N = 1'b0; FIFOADR = 2'b00; SLOE = 1'b1; SLRD = 1'b1; SLWR = 1'b1;
        PKTEND = 1'b1; FIFO_DATA_IN = '0; host_din = '0; host_wr_en = 1'b0;
        host_commit = 1'b0; host_rd_en = 1'b0;
        tick(); tick();
        check_reset_outputs("rst");
        RESET_N = 1'b1;
        tick(); tick();
        chk("idle_flagc", FLAGC, 0);
        chk("idle_flagb", FLAGB, 1);
        chk("idle_oe", FIFO_DATA_OE, 0);
        chk("idle_err", err, 0);

        // EP2: staged words stay invisible until committed
        for (int i = 1; i <= 4; i++) begin
            host_din = 16'(i); host_wr_en = 1'b1; ep2_q.push_back(16'(i));
            tick();
        end
        host_wr_en = 1'b0;
        chk("ep2_hfull", host_full, 0);
        chk("ep2_staged_dout", FIFO_DATA_OUT, 0);
        SLRD = 1'b0; tick(); SLRD = 1'b1;
        chk("ep2_underrun_err", err, 4'b0001);
        chk("ep2_underrun_flagc", FLAGC, 0);
        host_commit = 1'b1; tick(); host_commit = 1'b0;
        chk("ep2_commit_flagc", FLAGC, 1);
        SLOE = 1'b0; #1;
        chk("ep2_oe", FIFO_DATA_OE, 1);
        for (int i = 0; i < 4; i++) begin
            sb_ep2("ep2_read");
            SLRD = 1'b0; tick(); SLRD = 1'b1;
        end
        chk("ep2_drained_flagc", FLAGC, 0);
        chk("ep2_drained_err", err, 4'b0001);
        SLOE = 1'b1;

        // EP6: one full packet auto-commits
        for (int i = 0; i < 256; i++) begin
            fpga_write(16'h1000 + 16'(i), 1'b1);
            if (i == 254) chk("ep6_pre_commit_empty", host_empty, 1);
        end
        exp_pkt++;
        chk("ep6_auto_pkt", host_pkt_cnt, exp_pkt);
        chk("ep6_auto_empty", host_empty, 0);
        host_drain(256, "ep6_pkt_data");
        chk("ep6_drained_empty", host_empty, 1);
        host_rd_en = 1'b1; tick(); host_rd_en = 1'b0;
        chk("ep6_extra_rd_empty", host_empty, 1);
        chk("ep6_extra_rd_err", err, 4'b0001);
        chk("ep6_drained_flagc", FLAGC, 0);

        // EP6: short packet with PKTEND on the last write, then zero-length
        for (int i = 0; i < 4; i++) fpga_write(16'h2000 + 16'(i), 1'b1);
        chk("ep6_short_uncommitted", host_empty, 1);
        PKTEND = 1'b0;
        fpga_write(16'h2004, 1'b1);
        PKTEND = 1'b1;
        exp_pkt++;
        chk("ep6_short_pkt", host_pkt_cnt, exp_pkt);
        chk("ep6_short_empty", host_empty, 0);
        host_drain(5, "ep6_short_data");
        chk("ep6_short_drained", host_empty, 1);
        PKTEND = 1'b0; tick(); PKTEND = 1'b1;
        exp_pkt++;
        chk("ep6_zlp_pkt", host_pkt_cnt, exp_pkt);
        chk("ep6_zlp_empty", host_empty, 1);

        // EP6: fill to capacity, watch programmable and full flags, then overflow
        for (int i = 0; i < 1024; i++) begin
            fpga_write(16'h4000 + 16'(i), 1'b1);
            if (i == 766) chk("ep6_flaga_767", FLAGA, 1);
            if (i == 767) chk("ep6_flaga_768", FLAGA, 0);
            if (i == 1022) chk("ep6_flagb_1023", FLAGB, 1);
        end
        exp_pkt += 4;
        chk("ep6_flagb_full", FLAGB, 0);
        chk("ep6_fill_pkt", host_pkt_cnt, exp_pkt);
        fpga_write(16'hDEAD, 1'b0);
        chk("ep6_overrun_err", err, 4'b0011);
        chk("ep6_overrun_flagb", FLAGB, 0);
        chk("ep6_overrun_pkt", host_pkt_cnt, exp_pkt);
        host_drain(1024, "ep6_fill_data");
        chk("ep6_fill_drained", host_empty, 1);
        chk("ep6_fill_flaga", FLAGA, 1);

        // Strobe errors: simultaneous SLRD/SLWR, then illegal address
        FIFOADR = 2'b00;
        host_din = 16'hBEEF; host_wr_en = 1'b1; host_commit = 1'b1; ep2_q.push_back(16'hBEEF);
        tick();
        host_wr_en = 1'b0; host_commit = 1'b0;
        SLRD = 1'b0; SLWR = 1'b0; tick(); SLRD = 1'b1; SLWR = 1'b1;
        chk("both_err", err, 4'b1011);
        chk("both_flagc", FLAGC, 1);
        sb_ep2("both_no_pop");
        SLRD = 1'b0; tick(); SLRD = 1'b1;
        chk("both_after_read_flagc", FLAGC, 0);
        FIFOADR = 2'b01; SLWR = 1'b0; tick(); SLWR = 1'b1;
        chk("addr_err", err, 4'b1111);
        chk("addr_flagb", FLAGB, 0);
        chk("addr_flagc", FLAGC, 0);

        // Asynchronous reset in the middle of staged traffic
        fpga_write(16'h5000, 1'b0);
        fpga_write(16'h5001, 1'b0);
        host_din = 16'h7777; host_wr_en = 1'b1; tick(); host_wr_en = 1'b0;
        FIFOADR = 2'b00; SLOE = 1'b0;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        SLOE = 1'b1; RESET_N = 1'b1;
        tick();
        host_commit = 1'b1; tick(); host_commit = 1'b0;
        chk("midrst_ep2_discarded", FLAGC, 0);
        FIFOADR = 2'b10; PKTEND = 1'b0; tick(); PKTEND = 1'b1;
        chk("midrst_ep6_discarded", host_empty, 1);
        chk("midrst_pkt_restart", host_pkt_cnt, 1);
        chk("midrst_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hs_io_fx2_emu.md
Name: hs_io_fx2_emu

Overview:
- Synthesizable emulation of the Cypress FX2 side of the Slave FIFO high-speed interface; it is the counterpart of hs_io_v2.
- Serves two endpoints:
  - EP2: host->FPGA; the FPGA reads it.
  - EP6: FPGA->host; the FPGA writes it.
- On the host side it presents simple word FIFO ports, with packet commit semantics matching the FX2.
- Used for board-less loopback, bench stimulus and on-chip self-test of hs_io_v2 and the fifos behind it.

Parameters:
- EP2_DEPTH_LOG, 10, log2 of EP2 buffer depth in 16-bit words.
- EP6_DEPTH_LOG, 10, log2 of EP6 buffer depth in 16-bit words.
- PKT_WORDS, 256, EP6 auto-commit packet size in words (512 bytes).
- EP6_PROG_LEVEL, 768, EP6 fill level at or above which FLAGA asserts.

Ports:
- IFCLK  in  1  sole clock; all I/O sampled on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- FIFOADR  in  2  endpoint select: 00=EP2, 10=EP6, 01/11 illegal.
- SLOE  in  1  active-low output enable.
- SLRD  in  1  active-low read strobe.
- SLWR  in  1  active-low write strobe.
- PKTEND  in  1  active-low packet-end strobe.
- FIFO_DATA_IN  in  16  data written by the FPGA.
- FIFO_DATA_OUT  out  16  data driven toward the FPGA.
- FIFO_DATA_OE  out  1  high while the emulator drives the bus.
- FLAGA  out  1  active-low: EP6 fill >= EP6_PROG_LEVEL.
- FLAGB  out  1  active-low FULL of the addressed endpoint.
- FLAGC  out  1  active-low EMPTY of the addressed endpoint.
- host_din  in  16  EP2 load data.
- host_wr_en  in  1  EP2 load strobe.
- host_commit  in  1  makes staged EP2 words visible to the FPGA.
- host_full  out  1  EP2 full (committed plus staged).
- host_dout  out  16  EP6 head word, first-word-fall-through.
- host_rd_en  in  1  EP6 pop.
- host_empty  out  1  no committed EP6 words.
- host_pkt_cnt  out  16  EP6 packets committed, wrapping.
- err  out  4  sticky errors: {conflict, addr, overrun, underrun}.

Behaviour:
Reset:
- Both buffers are emptied and all pointers zeroed.
- FLAGB=1, FLAGC=0 (empty), FLAGA=1, FIFO_DATA_OE=0, FIFO_DATA_OUT=0.
- host_empty=1, host_full=0, host_pkt_cnt=0, err=0.
- Reset is asynchronous, so it may assert mid-packet; staged data is discarded.

Pointers:
- Each buffer has a write ptr, a commit ptr and a read ptr, each (DEPTH_LOG+1) bits and wrapping naturally.
- fill = wr - rd, the full/empty difference; committed = commit - rd.

EP2 (host -> FPGA):
- host_wr_en while !host_full: write at wr, wr+1. The word is staged and not yet visible to the FPGA.
- host_commit: commit <= wr, taking effect the next cycle. host_wr_en in the same cycle is included in the commit.
- FPGA-visible empty: committed == 0.
- FIFO_DATA_OUT = mem[rd] combinationally.
- FIFO_DATA_OE = !SLOE && FIFOADR==00.
- SLRD=0 && FIFOADR==00 at an edge: if committed>0 then rd+1; else set err[0] (underrun) and leave pointers unchanged.

EP6 (FPGA -> host):
- SLWR=0 && FIFOADR==10 at an edge: if fill<2^EP6_DEPTH_LOG, store FIFO_DATA_IN and wr+1; else drop the word and set err[1] (overrun).
- Auto-commit when wr - commit reaches PKT_WORDS: commit <= wr, host_pkt_cnt+1.
- PKTEND=0 && FIFOADR==10:
  - Commits the current uncommitted words, including a word written by SLWR in the same cycle.
  - With zero uncommitted words it is a zero-length packet: host_pkt_cnt+1 and pointers unchanged.
- Host side: host_empty = (committed==0). host_rd_en while !host_empty gives rd+1. host_rd_en while empty is ignored.

Flags:
- FLAGB/FLAGC are registered and reflect the FIFOADR sampled at the edge plus post-edge pointers, so they update one cycle after the strobe. This matches the FX2's one-cycle flag latency, which hs_io_v2 tolerates.
- EP2 FULL is reported as 0; EP6 EMPTY is computed on fill, not committed.
- Illegal address: FLAGB=0 and FLAGC=0 (full and empty), so a correct master stalls.

Strobe errors:
- SLRD, SLWR or PKTEND low with an illegal FIFOADR: ignored, err[2] set.
- SLRD and SLWR both low: both ignored, err[3] set.
- SLWR while FIFO_DATA_OE=1: bus contention; the write is ignored and err[3] is set.

Optional Feature:
- Macro: HS_IO_EMU_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 0xACE1, reloaded on reset) advances every cycle.
  - When LFSR[2:0]==0, registered FLAGB is forced to 0 and FLAGC to 0 for that cycle.
  - Strobes during a forced cycle still obey real occupancy. This stresses master flag handling without data loss.
- Not defined: the LFSR is absent and flags reflect true occupancy only.

Test Plan:
- Reset, then idle with FIFOADR=00 -> FLAGC=0, FLAGB=1, FIFO_DATA_OE=0, err=0.
- Host loads 0x0001..0x0004 without commit, then FPGA reads with FIFOADR=00/SLRD=0 -> FLAGC stays 0, err[0] set. After host_commit, four reads return 0x0001..0x0004; FLAGC=0 one cycle after the 4th.
- FPGA writes 256 words to EP6 -> host_pkt_cnt=1, host_empty=0. Host drains exactly 256 words in order; the 257th host_rd_en is ignored.
- 5 words to EP6, then PKTEND=0 -> host_pkt_cnt=1 and 5 words visible. A second PKTEND=0 with none pending -> host_pkt_cnt=2, no data.
- Fill EP6 to 1024 words -> FLAGA=0 from word 768, FLAGB=0 after word 1024. The 1025th SLWR is dropped and err[1] is set.
- SLRD=0 and SLWR=0 together with FIFOADR=00 -> no pointer change, err[3]=1. FIFOADR=01 with SLWR=0 -> err[2]=1. Assert RESET_N=0 mid-packet -> all outputs return to reset values immediately.
